trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Sequences machine-mode trap entry and return for the RV64 NPC core. Sits after the decoder and
//  its illegal-instruction checker. Converts illegal/ecall/mret/ebreak events into ordered writes on
//  the single CSR write port, stalls the core while writing, then issues one PC redirect.
//  Also counts traps taken.
// PARAMETERS
//  XLEN       64  data/PC width
//  HAS_MTVAL  1   1: write mtval during trap entry; 0: skip the W_MTVAL state
// PORTS
//  clk            in   1     core clock
//  rst            in   1     synchronous, active-high reset
//  inst_valid     in   1     decoded instruction in the event stage is valid this cycle
//  pc             in   XLEN  PC of that instruction
//  inst           in   32    raw instruction word
//  illegal        in   1     decoder flagged the instruction as unknown
//  is_ecall       in   1     instruction is ecall
//  is_mret        in   1     instruction is mret
//  is_ebreak      in   1     instruction is ebreak
//  mtvec_i        in   XLEN  current mtvec (combinational CSR read)
//  mepc_i         in   XLEN  current mepc
//  mstatus_i      in   XLEN  current mstatus
//  csr_we         out  1     CSR write strobe
//  csr_waddr      out  12    CSR write address
//  csr_wdata      out  XLEN  CSR write data
//  stall          out  1     freeze fetch/decode/writeback of the current instruction
//  redirect_valid out  1     one-cycle pulse: load redirect_pc into PC
//  redirect_pc    out  XLEN  redirect target
//  halt           out  1     ebreak reached; simulation end
//  trap_cnt       out  32    number of trap entries completed (wraps at 2^32)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; trap_cnt=0; latched pc/inst/cause=0. rst mid-sequence aborts
//   to IDLE next edge. CSR writes already issued stay; no further writes are issued.
//  Event (IDLE only): ev = inst_valid & (illegal|is_ecall|is_mret|is_ebreak).
//   Priority: illegal > ecall > mret > ebreak. In non-IDLE states inputs are ignored.
//  stall = (state!=IDLE) | ev (combinational, asserted in the detect cycle).
//  On ev the block latches pc, inst, and cause: illegal=2, ecall=11 (cause[63]=0).
//  FSM and CSR writes (one per state, csr_we=1 only in W_* states):
//   IDLE  -illegal/ecall-> W_MEPC; -mret-> W_MRET; -ebreak-> HALT; else IDLE
//   W_MEPC   : 0x341 <= latched pc                                   -> W_MCAUSE
//   W_MCAUSE : 0x342 <= cause                                        -> W_MTVAL (HAS_MTVAL) / W_MSTATUS
//   W_MTVAL  : 0x343 <= illegal ? zero-ext inst : 0                  -> W_MSTATUS
//   W_MSTATUS: 0x300 <= mstatus_i with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11 -> REDIR_T
//   W_MRET   : 0x300 <= mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b11   -> REDIR_R
//   REDIR_T  : redirect_valid=1, redirect_pc={mtvec_i[XLEN-1:2],2'b00}, trap_cnt+=1 -> IDLE
//   REDIR_R  : redirect_valid=1, redirect_pc=mepc_i                  -> IDLE
//   HALT     : halt=1, stall=1; exit only by rst
//  Latency from detect edge: trap redirect 5 cycles (4 if HAS_MTVAL=0); mret redirect 2 cycles.
//  The mtvec mode bits are masked, so direct mode is always used. mstatus is read in the same
//   cycle it is written; other bits pass through unchanged.
//  redirect_pc, csr_waddr and csr_wdata are 0 when their strobe is low. trap_cnt wraps
//   0xFFFFFFFF->0.
//  Back-to-back: an event in the cycle after REDIR_* is accepted normally from IDLE.
// TESTING
//  1 illegal inst=0xFFFFFFFF, pc=0x80000010, mtvec_i=0x80001003, mstatus_i=0x8 -> writes
//    341=0x80000010, 342=2, 343=0xFFFFFFFF, 300=0x1880 on cycles 1-4; redirect 0x80001000 at
//    cycle 5; trap_cnt=1.
//  2 ecall with HAS_MTVAL=0 -> writes 341, 342=11, 300 only; redirect at cycle 4; stall high
//    from cycle 0 through cycle 4.
//  3 mret, mstatus_i=0x1880, mepc_i=0x80000014 -> 300=0x1888 at cycle 1; redirect 0x80000014
//    at cycle 2; trap_cnt unchanged.
//  4 illegal and is_ebreak both high -> trap sequence taken, no halt. Lone ebreak -> halt=1
//    permanently; later events are ignored.
//  5 rst asserted during W_MCAUSE -> next cycle IDLE, csr_we=0, no redirect, trap_cnt unchanged.
//  6 preload trap_cnt=0xFFFFFFFF (force) then one ecall -> trap_cnt=0; inst_valid=0 with
//    illegal=1 -> no stall, no writes.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/return sequencer: turns illegal/ecall/mret/ebreak events into
// ordered CSR writes on a single write port, stalls the core meanwhile, then redirects the PC.
module trap_ctrl #(
  parameter int XLEN      = 64,
  parameter int HAS_MTVAL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            illegal,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic            is_ebreak,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mstatus_i,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            halt,
  output logic [31:0]     trap_cnt
);

  typedef enum logic [3:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, W_MRET, REDIR_T, REDIR_R, HALT
  } state_t;

  state_t          r_state, w_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            r_ill;
  logic [31:0]     r_trap_cnt;
  logic            w_ev;
  logic [XLEN-1:0] w_mst_trap, w_mst_mret;
  logic            w_unused;

  // mode bits of mtvec are dropped: direct mode only
  assign w_unused = ^mtvec_i[1:0];

  assign w_ev = (r_state == IDLE) & inst_valid & (illegal | is_ecall | is_mret | is_ebreak);

  always_comb begin
    w_mst_trap        = mstatus_i;
    w_mst_trap[7]     = mstatus_i[3];
    w_mst_trap[3]     = 1'b0;
    w_mst_trap[12:11] = 2'b11;
    w_mst_mret        = mstatus_i;
    w_mst_mret[3]     = mstatus_i[7];
    w_mst_mret[7]     = 1'b1;
    w_mst_mret[12:11] = 2'b11;
  end

  // state register plus event latches and the trap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_inst     <= '0;
      r_ill      <= 1'b0;
      r_trap_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_ev) begin
        r_pc   <= pc;
        r_inst <= inst;
        r_ill  <= illegal;
      end
      if (r_state == REDIR_T) r_trap_cnt <= r_trap_cnt + 32'd1;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_ev) begin
          if (illegal | is_ecall) w_nxt = W_MEPC;
          else if (is_mret)       w_nxt = W_MRET;
          else                    w_nxt = HALT;
        end
      end
      W_MEPC:    w_nxt = W_MCAUSE;
      W_MCAUSE:  w_nxt = (HAS_MTVAL != 0) ? W_MTVAL : W_MSTATUS;
      W_MTVAL:   w_nxt = W_MSTATUS;
      W_MSTATUS: w_nxt = REDIR_T;
      W_MRET:    w_nxt = REDIR_R;
      REDIR_T:   w_nxt = IDLE;
      REDIR_R:   w_nxt = IDLE;
      HALT:      w_nxt = HALT;
      default:   w_nxt = IDLE;
    endcase
  end

  always_comb begin
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    stall          = (r_state != IDLE) | w_ev;
    case (r_state)
      W_MEPC:    begin csr_we = 1'b1; csr_waddr = 12'h341; csr_wdata = r_pc; end
      W_MCAUSE:  begin csr_we = 1'b1; csr_waddr = 12'h342;
                       csr_wdata = r_ill ? XLEN'(2) : XLEN'(11); end
      W_MTVAL:   begin csr_we = 1'b1; csr_waddr = 12'h343;
                       csr_wdata = r_ill ? XLEN'(r_inst) : '0; end
      W_MSTATUS: begin csr_we = 1'b1; csr_waddr = 12'h300; csr_wdata = w_mst_trap; end
      W_MRET:    begin csr_we = 1'b1; csr_waddr = 12'h300; csr_wdata = w_mst_mret; end
      REDIR_T:   begin redirect_valid = 1'b1; redirect_pc = {mtvec_i[XLEN-1:2], 2'b00}; end
      REDIR_R:   begin redirect_valid = 1'b1; redirect_pc = mepc_i; end
      HALT:      halt = 1'b1;
      default:   ;
    endcase
  end

  assign trap_cnt = r_trap_cnt;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl; a HAS_MTVAL=1 and a HAS_MTVAL=0 instance share one stimulus.
module tb_trap_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_valid = 0, illegal = 0, is_ecall = 0, is_mret = 0, is_ebreak = 0;
  logic [63:0] pc = '0, mtvec_i = '0, mepc_i = '0, mstatus_i = '0;
  logic [31:0] inst = '0;
  logic        we1, st1, rv1, h1, we0, st0, rv0, h0;
  logic [11:0] wa1, wa0;
  logic [63:0] wd1, rp1, wd0, rp0;
  logic [31:0] tc1, tc0;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(64), .HAS_MTVAL(1)) u_dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc), .inst(inst), .illegal(illegal),
    .is_ecall(is_ecall), .is_mret(is_mret), .is_ebreak(is_ebreak), .mtvec_i(mtvec_i),
    .mepc_i(mepc_i), .mstatus_i(mstatus_i), .csr_we(we1), .csr_waddr(wa1), .csr_wdata(wd1),
    .stall(st1), .redirect_valid(rv1), .redirect_pc(rp1), .halt(h1), .trap_cnt(tc1));

  trap_ctrl #(.XLEN(64), .HAS_MTVAL(0)) u_dut0 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc), .inst(inst), .illegal(illegal),
    .is_ecall(is_ecall), .is_mret(is_mret), .is_ebreak(is_ebreak), .mtvec_i(mtvec_i),
    .mepc_i(mepc_i), .mstatus_i(mstatus_i), .csr_we(we0), .csr_waddr(wa0), .csr_wdata(wd0),
    .stall(st0), .redirect_valid(rv0), .redirect_pc(rp0), .halt(h0), .trap_cnt(tc0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    inst_valid = 0; illegal = 0; is_ecall = 0; is_mret = 0; is_ebreak = 0;
  endtask

  task automatic csr1(input string tag, input logic we, input logic [11:0] a, input logic [63:0] d);
    chk({tag, "_we"}, 64'(we1), 64'(we));
    chk({tag, "_addr"}, 64'(wa1), 64'(a));
    chk({tag, "_data"}, wd1, d);
  endtask

  task automatic csr0(input string tag, input logic we, input logic [11:0] a, input logic [63:0] d);
    chk({tag, "_we0"}, 64'(we0), 64'(we));
    chk({tag, "_addr0"}, 64'(wa0), 64'(a));
    chk({tag, "_data0"}, wd0, d);
  endtask

  initial begin
    tick(); tick(); rst = 0; #1;
    chk("rst_we", 64'(we1), 0);     chk("rst_stall", 64'(st1), 0);
    chk("rst_rv", 64'(rv1), 0);     chk("rst_halt", 64'(h1), 0);
    chk("rst_cnt", 64'(tc1), 0);    chk("rst_rpc", rp1, 0);

    // reset during W_MCAUSE
    pc = 64'h80000100; inst = 32'h0000_0000; mtvec_i = 64'h80001000;
    inst_valid = 1; illegal = 1; #1;
    chk("t5_stall0", 64'(st1), 1);
    tick(); clr(); #1;
    csr1("t5_c1", 1, 12'h341, 64'h80000100);
    tick();
    csr1("t5_c2", 1, 12'h342, 64'd2);
    rst = 1;
    tick(); rst = 0; #1;
    csr1("t5_c3", 0, 12'h000, 0);
    chk("t5_rv", 64'(rv1), 0); chk("t5_stall", 64'(st1), 0);
    for (int i = 0; i < 6; i++) begin
      tick(); chk("t5_idle_rv", 64'(rv1 | we1), 0);
    end
    chk("t5_cnt", 64'(tc1), 0);

    // illegal instruction trap, full sequence
    pc = 64'h80000010; inst = 32'hFFFFFFFF; mtvec_i = 64'h80001003; mstatus_i = 64'h8;
    inst_valid = 1; illegal = 1; #1;
    chk("t1_stall0", 64'(st1), 1); chk("t1_we0", 64'(we1), 0);
    tick(); clr(); pc = 0; inst = 0; #1;
    csr1("t1_c1", 1, 12'h341, 64'h80000010);
    tick(); csr1("t1_c2", 1, 12'h342, 64'd2);
    tick(); csr1("t1_c3", 1, 12'h343, 64'hFFFFFFFF);
    tick(); csr1("t1_c4", 1, 12'h300, 64'h1880);
    chk("t1_rv4", 64'(rv1), 0);
    tick(); chk("t1_rv5", 64'(rv1), 1); chk("t1_rpc", rp1, 64'h80001000);
    csr1("t1_c5", 0, 12'h000, 0);
    tick(); chk("t1_cnt", 64'(tc1), 1); chk("t1_stall6", 64'(st1), 0); chk("t1_rv6", 64'(rv1), 0);

    // ecall; checks the HAS_MTVAL=0 instance (4-cycle path) and mtval=0 on the other
    pc = 64'h80000020; inst = 32'h00000073; mtvec_i = 64'h80002001; mstatus_i = 64'h0;
    inst_valid = 1; is_ecall = 1; #1;
    chk("t2_stall0", 64'(st0), 1);
    tick(); clr(); #1;
    csr0("t2_c1", 1, 12'h341, 64'h80000020); chk("t2_stall1", 64'(st0), 1);
    tick(); csr0("t2_c2", 1, 12'h342, 64'd11); chk("t2_stall2", 64'(st0), 1);
    tick(); csr0("t2_c3", 1, 12'h300, 64'h1800); chk("t2_stall3", 64'(st0), 1);
    csr1("t2_mtval", 1, 12'h343, 0);
    tick(); chk("t2_rv4", 64'(rv0), 1); chk("t2_rpc4", rp0, 64'h80002000);
    chk("t2_stall4", 64'(st0), 1); csr0("t2_c4", 0, 12'h000, 0);
    tick(); chk("t2_stall5", 64'(st0), 0); chk("t2_cnt0", 64'(tc0), 2);
    chk("t2_rv1_5", 64'(rv1), 1);
    tick(); chk("t2_cnt1", 64'(tc1), 2);

    // mret, then back-to-back ecall with the counter preloaded to wrap
    mstatus_i = 64'h1880; mepc_i = 64'h80000014;
    inst_valid = 1; is_mret = 1; #1;
    tick(); clr(); #1;
    csr1("t3_c1", 1, 12'h300, 64'h1888);
    force u_dut.r_trap_cnt = 32'hFFFFFFFF;
    #1 release u_dut.r_trap_cnt;
    tick(); chk("t3_rv", 64'(rv1), 1); chk("t3_rpc", rp1, 64'h80000014);
    chk("t3_cnt_pre", 64'(tc1), 64'hFFFFFFFF); chk("t3_cnt0", 64'(tc0), 2);
    tick();
    pc = 64'h80000030; mtvec_i = 64'h80003000; mstatus_i = 64'h0;
    inst_valid = 1; is_ecall = 1; #1;
    chk("t6_b2b_stall", 64'(st1), 1);
    tick(); clr(); #1;
    csr1("t6_c1", 1, 12'h341, 64'h80000030);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_rv", 64'(rv1), 1); chk("t6_rpc", rp1, 64'h80003000);
    tick(); chk("t6_wrap", 64'(tc1), 0);

    // not valid: no stall, no writes
    inst_valid = 0; illegal = 1; #1;
    chk("t6_nv_stall", 64'(st1), 0);
    tick(); chk("t6_nv_we", 64'(we1), 0); chk("t6_nv_stall1", 64'(st1), 0);
    clr();

    // illegal beats ebreak
    pc = 64'h80000040; inst = 32'h00100073; mtvec_i = 64'h80001000; mstatus_i = 64'h0;
    inst_valid = 1; illegal = 1; is_ebreak = 1;
    tick(); clr(); #1;
    csr1("t4_c1", 1, 12'h341, 64'h80000040); chk("t4_halt1", 64'(h1), 0);
    tick(); csr1("t4_c2", 1, 12'h342, 64'd2);
    for (int i = 0; i < 3; i++) tick();
    chk("t4_rv", 64'(rv1), 1); chk("t4_halt", 64'(h1), 0);
    tick();

    // lone ebreak halts for good
    inst_valid = 1; is_ebreak = 1;
    tick(); clr(); #1;
    chk("t4_h1", 64'(h1), 1); chk("t4_hstall", 64'(st1), 1); chk("t4_hwe", 64'(we1), 0);
    inst_valid = 1; illegal = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold", {61'd0, h1, we1, rv1}, 64'b100);
    end
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
